// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_arbiter
//  Description : Shares one registered W x W unsigned multiplier between NREQ
//                requesters. A round-robin arbiter accepts at most one
//                operand pair per cycle and tags it with the requester ID.
//                Two pipeline stages (operand register -> product register)
//                return the tagged 2W-bit product, with valid/ready
//                backpressure on the result side.
//  Ports       : clk        rising-edge clock
//                reset      synchronous, active-high reset
//                req        per-requester request
//                a_in/b_in  packed operands, requester i at [i*W +: W]
//                gnt        one-hot accept strobe (combinational)
//                out_valid  result valid
//                out_ready  consumer ready
//                out_id     requester ID of the result
//                out_data   unsigned product a*b
//                busy       either pipeline stage holds valid data
//  Revision    : 1.0  initial release
// ============================================================================
module mul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   a_in,
    input  logic [NREQ*W-1:0]   b_in,
    output logic [NREQ-1:0]     gnt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDW-1:0]      out_id,
    output logic [2*W-1:0]      out_data,
    output logic                busy
);

    localparam logic [IDW-1:0] C_LAST_ID = IDW'(NREQ - 1);

    // Stage 1: operand register
    logic           v1_q;
    logic [W-1:0]   a1_q;
    logic [W-1:0]   b1_q;
    logic [IDW-1:0] id1_q;

    // Stage 2: product register (drives the outputs directly)
    logic           v2_q;
    logic [2*W-1:0] prod_q;
    logic [IDW-1:0] id2_q;

    // Round-robin pointer: the requester with highest priority next
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    logic           w_adv1;
    logic           w_adv2;
    logic           w_found;
    logic [IDW-1:0] w_idx;
    logic [2*W-1:0] w_prod;

    // A stage may load when it is empty or its contents move on this edge.
    assign w_adv2 = !v2_q || out_ready;
    assign w_adv1 = !v1_q || w_adv2;

    // Circular search starting at ptr; the first requester found wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(ptr_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_idx   = IDW'(j);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (w_found && w_adv1 && !reset) begin
            gnt[w_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = (w_idx == C_LAST_ID) ? '0 : w_idx + 1'b1;
    end

    assign w_prod = {{W{1'b0}}, a1_q} * {{W{1'b0}}, b1_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            id1_q  <= '0;
            v2_q   <= 1'b0;
            prod_q <= '0;
            id2_q  <= '0;
            ptr_q  <= '0;
        end else begin
            if (w_adv2) begin
                v2_q   <= v1_q;
                prod_q <= w_prod;
                id2_q  <= id1_q;
            end
            if (w_adv1) begin
                v1_q <= |gnt;
                if (|gnt) begin
                    a1_q  <= a_in[w_idx*W +: W];
                    b1_q  <= b_in[w_idx*W +: W];
                    id1_q <= w_idx;
                    ptr_q <= ptr_d;
                end
            end
        end
    end

    assign out_valid = v2_q;
    assign out_data  = prod_q;
    assign out_id    = id2_q;
    assign busy      = v1_q | v2_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_share_arbiter
//  Description : Directed self-checking bench for mul_share_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   a_in;
    logic [NREQ*W-1:0]   b_in;
    logic [NREQ-1:0]     gnt;
    logic                out_valid;
    logic                out_ready;
    logic [IDW-1:0]      out_id;
    logic [2*W-1:0]      out_data;
    logic                busy;

    int n_tests;
    int n_fail;

    mul_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    task automatic check_out(input string tag, input logic [IDW-1:0] id, input logic [2*W-1:0] data);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_id"},    32'(out_id),    32'(id));
        check({tag, "_data"},  32'(out_data),  32'(data));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req       = 4'b1111;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b1;

        // ---------------- reset state ----------------
        step();
        step();
        #1;
        check("rst_gnt",   32'(gnt),       32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_id",    32'(out_id),    32'd0);
        req   = '0;
        reset = 1'b0;
        step();

        // ---------------- T1 latency ----------------
        set_op(0, 8'd5, 8'd7);
        req = 4'b0001;
        #1;
        check("t1_gnt", 32'(gnt), 32'h1);
        step();
        req = '0;
        check("t1_busy_s1",   32'(busy),      32'd1);
        check("t1_valid_early", 32'(out_valid), 32'd0);
        step();
        check_out("t1_out", 2'd0, 16'd35);
        step();
        check("t1_valid_once", 32'(out_valid), 32'd0);
        check("t1_idle",       32'(busy),      32'd0);

        // ---------------- T2 round robin (pointer reset to 0) ----------------
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, 8'(i + 1), 8'd10);
        end
        for (int c = 0; c < 7; c++) begin
            req = (c < 5) ? 4'b1111 : 4'b0000;
            #1;
            check($sformatf("t2_gnt%0d", c), 32'(gnt),
                  (c < 5) ? (32'd1 << (c % 4)) : 32'd0);
            if (c >= 2) begin
                check_out($sformatf("t2_out%0d", c), 2'((c - 2) % 4),
                          16'((((c - 2) % 4) + 1) * 10));
            end
            step();
        end
        check("t2_drained", 32'(out_valid), 32'd0);

        // ---------------- T3 wrap (ptr=1 here) ----------------
        req = 4'b1000;
        #1;
        check("t3_gnt3", 32'(gnt), 32'h8);
        step();
        req = 4'b1100;
        #1;
        check("t3_gnt_wrap", 32'(gnt), 32'h4);
        step();
        #1;
        check("t3_gnt_next", 32'(gnt), 32'h8);
        check_out("t3_out0", 2'd3, 16'd40);
        step();
        req = '0;
        check_out("t3_out1", 2'd2, 16'd30);
        step();
        check_out("t3_out2", 2'd3, 16'd40);
        step();
        check("t3_drained", 32'(out_valid), 32'd0);

        // ---------------- T4 backpressure (ptr=0) ----------------
        set_op(0, 8'd11, 8'd3);
        set_op(1, 8'd12, 8'd4);
        set_op(2, 8'd13, 8'd5);
        req = 4'b0001;
        #1;
        check("t4_gnt0", 32'(gnt), 32'h1);
        step();
        req = 4'b0010;
        #1;
        check("t4_gnt1", 32'(gnt), 32'h2);
        step();
        out_ready = 1'b0;
        req       = 4'b0100;
        for (int s = 0; s < 3; s++) begin
            #1;
            check($sformatf("t4_stall_gnt%0d", s), 32'(gnt), 32'd0);
            check_out($sformatf("t4_stall%0d", s), 2'd0, 16'd33);
            check($sformatf("t4_stall_busy%0d", s), 32'(busy), 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("t4_release_gnt", 32'(gnt), 32'h4);
        check_out("t4_rel0", 2'd0, 16'd33);
        step();
        req = '0;
        check_out("t4_rel1", 2'd1, 16'd48);
        step();
        check_out("t4_rel2", 2'd2, 16'd65);
        step();
        check("t4_drained", 32'(out_valid), 32'd0);
        check("t4_idle",    32'(busy),      32'd0);

        // ---------------- T5 width (ptr=3) ----------------
        set_op(0, 8'd255, 8'd255);
        set_op(1, 8'd0,   8'd200);
        req = 4'b0001;
        #1;
        check("t5_gnt0", 32'(gnt), 32'h1);
        step();
        req = 4'b0010;
        #1;
        check("t5_gnt1", 32'(gnt), 32'h2);
        step();
        req = '0;
        check_out("t5_max", 2'd0, 16'hFE01);
        step();
        check_out("t5_zero", 2'd1, 16'd0);
        step();

        // ---------------- T6 reset mid-flight (ptr=2) ----------------
        set_op(0, 8'd5, 8'd7);
        set_op(1, 8'd9, 8'd9);
        req = 4'b0001;
        step();
        req = 4'b0010;
        step();
        req = '0;
        check("t6_full_busy",  32'(busy),      32'd1);
        check("t6_full_valid", 32'(out_valid), 32'd1);
        check("t6_full_s1",    32'(u_dut.v1_q), 32'd1);
        reset = 1'b1;
        req   = 4'b0011;
        #1;
        check("t6_rst_gnt", 32'(gnt), 32'd0);
        step();
        reset = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_busy",  32'(busy),      32'd0);
        check("t6_data",  32'(out_data),  32'd0);
        #1;
        check("t6_gnt_ptr0", 32'(gnt), 32'h1);
        step();
        req = '0;
        check("t6_no_stale", 32'(out_valid), 32'd0);
        step();
        check_out("t6_out", 2'd0, 16'd35);
        step();
        check("t6_drained", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
